// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative multiply/divide unit for the MIPS execute stage.
// It computes one bit per clock and holds its results in the architectural
// HI/LO registers.
//
// Operations (op):
//   000 MULTU   001 MULT   010 DIVU   011 DIV   100 MTHI   101 MTLO
//   110 and 111 do nothing.
//
// Ports:
//   clk, rst      single clock; asynchronous active-high reset
//   start, op     request; sampled only while busy=0
//   src_a, src_b  operands (src_a is also the MTHI/MTLO data)
//   flush         abandons the operation in flight; hi/lo are left unchanged
//   busy          registered; high while an operation is in flight
//   done          one-cycle pulse when hi/lo receive a result
//   div_by_zero   qualified by done
//   hi, lo        product upper/lower half, or remainder/quotient
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0]   ZERO_W   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]   ONES_W   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   ZERO_CNT = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   ONE_CNT  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(WIDTH - 1);

  // Two's-complement negation helpers.
  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return ~v + ONE_W;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
    return ~v + ONE_2W;
  endfunction

  state_t             state_r, state_nx_s;
  logic [CNT_W-1:0]   cnt_r;
  // Shared datapath registers:
  //   multiply: upper_r = partial product upper half,
  //             lower_r = multiplier (shifted out) / product lower half
  //   divide:   upper_r = partial remainder,
  //             lower_r = dividend (shifted out) / quotient
  logic [WIDTH-1:0]   upper_r, lower_r, mcand_r;
  logic               is_div_r, dbz_r, neg_hi_r, neg_lo_r;
  logic [WIDTH-1:0]   hi_r, lo_r;
  logic               busy_r, done_r, dbz_out_r;

  logic               latch_s, dbz_start_s, step_s, finish_s, mthi_s, mtlo_s;
  logic               a_neg_s, b_neg_s, sign_q_s;
  logic [WIDTH-1:0]   a_mag_s, b_mag_s;
  logic [WIDTH:0]     mul_sum_s, div_trial_s;
  logic [WIDTH-1:0]   upper_nx_s, lower_nx_s;
  logic [2*WIDTH-1:0] prod_fix_s;
  logic [WIDTH-1:0]   fin_hi_s, fin_lo_s;

  assign busy        = busy_r;
  assign done        = done_r;
  assign div_by_zero = dbz_out_r;
  assign hi          = hi_r;
  assign lo          = lo_r;

  // Operand magnitudes and result signs, taken at the accepting edge.
  always_comb begin
    a_neg_s  = op[0] & src_a[WIDTH-1];
    b_neg_s  = op[0] & src_b[WIDTH-1];
    a_mag_s  = a_neg_s ? neg_w(src_a) : src_a;
    b_mag_s  = b_neg_s ? neg_w(src_b) : src_b;
    sign_q_s = a_neg_s ^ b_neg_s;
  end

  // Next-state and control-strobe decode.
  always_comb begin
    state_nx_s  = state_r;
    latch_s     = 1'b0;
    dbz_start_s = 1'b0;
    step_s      = 1'b0;
    finish_s    = 1'b0;
    mthi_s      = 1'b0;
    mtlo_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // flush takes priority over start, even in IDLE
        if (start && !flush) begin
          if (!op[2]) begin
            latch_s = 1'b1;
            if (op[1] && (src_b == ZERO_W)) begin
              // A zero divisor skips the iterations entirely.
              dbz_start_s = 1'b1;
              state_nx_s  = ST_FINISH;
            end else begin
              state_nx_s = ST_RUN;
            end
          end else if (op == 3'b100) begin
            mthi_s = 1'b1;
          end else if (op == 3'b101) begin
            mtlo_s = 1'b1;
          end else begin
            state_nx_s = ST_IDLE;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (flush) begin
          state_nx_s = ST_IDLE;
        end else begin
          step_s = 1'b1;
          if (cnt_r == LAST_CNT) begin
            state_nx_s = ST_FINISH;
          end else begin
            state_nx_s = ST_RUN;
          end
        end
      end
      ST_FINISH: begin
        if (flush) begin
          state_nx_s = ST_IDLE;
        end else begin
          finish_s   = 1'b1;
          state_nx_s = ST_IDLE;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // One iteration step: shift-add for multiply, restoring shift-subtract for divide.
  always_comb begin
    mul_sum_s   = {1'b0, upper_r} + (lower_r[0] ? {1'b0, mcand_r} : {1'b0, ZERO_W});
    div_trial_s = {upper_r, lower_r[WIDTH-1]} - {1'b0, mcand_r};
    if (is_div_r) begin
      if (!div_trial_s[WIDTH]) begin
        // The trial remainder is below the divisor, so it fits in WIDTH bits.
        upper_nx_s = div_trial_s[WIDTH-1:0];
        lower_nx_s = {lower_r[WIDTH-2:0], 1'b1};
      end else begin
        upper_nx_s = {upper_r[WIDTH-2:0], lower_r[WIDTH-1]};
        lower_nx_s = {lower_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      upper_nx_s = mul_sum_s[WIDTH:1];
      lower_nx_s = {mul_sum_s[0], lower_r[WIDTH-1:1]};
    end
  end

  // Sign correction and result selection applied in FINISH.
  always_comb begin
    prod_fix_s = neg_lo_r ? neg_2w({upper_r, lower_r}) : {upper_r, lower_r};
    if (dbz_r) begin
      fin_hi_s = upper_r;
      fin_lo_s = ONES_W;
    end else if (is_div_r) begin
      fin_hi_s = neg_hi_r ? neg_w(upper_r) : upper_r;
      fin_lo_s = neg_lo_r ? neg_w(lower_r) : lower_r;
    end else begin
      fin_hi_s = prod_fix_s[2*WIDTH-1:WIDTH];
      fin_lo_s = prod_fix_s[WIDTH-1:0];
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Operand latch and iteration datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r    <= ZERO_CNT;
      upper_r  <= ZERO_W;
      lower_r  <= ZERO_W;
      mcand_r  <= ZERO_W;
      is_div_r <= 1'b0;
      dbz_r    <= 1'b0;
      neg_hi_r <= 1'b0;
      neg_lo_r <= 1'b0;
    end else if (latch_s) begin
      cnt_r    <= ZERO_CNT;
      is_div_r <= op[1];
      dbz_r    <= dbz_start_s;
      if (dbz_start_s) begin
        // A zero divisor returns the raw dividend in HI.
        upper_r  <= src_a;
        lower_r  <= ZERO_W;
        mcand_r  <= ZERO_W;
        neg_hi_r <= 1'b0;
        neg_lo_r <= 1'b0;
      end else if (op[1]) begin
        upper_r  <= ZERO_W;
        lower_r  <= a_mag_s;
        mcand_r  <= b_mag_s;
        neg_hi_r <= a_neg_s;
        neg_lo_r <= sign_q_s;
      end else begin
        upper_r  <= ZERO_W;
        lower_r  <= b_mag_s;
        mcand_r  <= a_mag_s;
        neg_hi_r <= sign_q_s;
        neg_lo_r <= sign_q_s;
      end
    end else if (step_s) begin
      upper_r <= upper_nx_s;
      lower_r <= lower_nx_s;
      cnt_r   <= cnt_r + ONE_CNT;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Architectural HI/LO registers and the registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_r      <= ZERO_W;
      lo_r      <= ZERO_W;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      dbz_out_r <= 1'b0;
    end else begin
      if (finish_s) begin
        hi_r <= fin_hi_s;
        lo_r <= fin_lo_s;
      end else if (mthi_s) begin
        hi_r <= src_a;
      end else if (mtlo_s) begin
        lo_r <= src_a;
      end else begin
        hi_r <= hi_r;
      end
      busy_r    <= (state_nx_s != ST_IDLE);
      done_r    <= finish_s;
      dbz_out_r <= finish_s & dbz_r;
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Testbench for mul_div_unit. It drives a WIDTH=32 instance and a WIDTH=8
// instance, and checks hi/lo/done/busy/div_by_zero against constant vectors
// and against a reference model that uses plain integer arithmetic.
module tb_mul_div_unit;

  localparam logic [2:0] OP_MULTU = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_DIVU  = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_NOP   = 3'b111;

  logic        clk, rst;
  logic        start, flush, busy, done, dbz;
  logic [2:0]  op;
  logic [31:0] src_a, src_b, hi, lo;
  logic        start8, flush8, busy8, done8, dbz8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8, hi8, lo8;

  logic        sel8;
  logic        m_busy, m_done, m_dbz;
  logic [31:0] m_hi, m_lo;

  int n_cmp = 0;
  int n_err = 0;

  mul_div_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .flush(flush), .busy(busy), .done(done), .div_by_zero(dbz), .hi(hi), .lo(lo)
  );

  mul_div_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .src_a(a8), .src_b(b8),
    .flush(flush8), .busy(busy8), .done(done8), .div_by_zero(dbz8), .hi(hi8), .lo(lo8)
  );

  assign m_busy = sel8 ? busy8 : busy;
  assign m_done = sel8 ? done8 : done;
  assign m_dbz  = sel8 ? dbz8  : dbz;
  assign m_hi   = sel8 ? {24'd0, hi8} : hi;
  assign m_lo   = sel8 ? {24'd0, lo8} : lo;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (sel8) begin
      start8 = s; op8 = o; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      start = s; op = o; src_a = a; src_b = b;
    end
  endtask

  // Reference model: WIDTH-w arithmetic written with 64-bit integers.
  function automatic void ref_model(input int w, input logic [2:0] opc,
                                    input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] rhi, output logic [31:0] rlo,
                                    output logic rdbz);
    longint unsigned mask, ua, ub, up;
    longint sa, sb, sp, sq, sr;
    mask = (64'd1 << w) - 64'd1;
    ua = {32'd0, a} & mask;
    ub = {32'd0, b} & mask;
    sa = ua[w-1] ? $signed(ua) - $signed(64'd1 << w) : $signed(ua);
    sb = ub[w-1] ? $signed(ub) - $signed(64'd1 << w) : $signed(ub);
    rdbz = 1'b0;
    rhi = 32'd0;
    rlo = 32'd0;
    case (opc)
      OP_MULTU: begin
        up = ua * ub;
        rhi = 32'((up >> w) & mask);
        rlo = 32'(up & mask);
      end
      OP_MULT: begin
        sp = sa * sb;
        up = $unsigned(sp);
        rhi = 32'((up >> w) & mask);
        rlo = 32'(up & mask);
      end
      default: begin
        if (ub == 64'd0) begin
          rdbz = 1'b1;
          rhi = 32'(ua);
          rlo = 32'(mask);
        end else if (opc == OP_DIVU) begin
          rlo = 32'(ua / ub);
          rhi = 32'(ua % ub);
        end else begin
          sq = sa / sb;
          sr = sa % sb;
          rlo = 32'($unsigned(sq) & mask);
          rhi = 32'($unsigned(sr) & mask);
        end
      end
    endcase
  endfunction

  // Issue one operation on the selected instance and wait, within a bounded
  // number of cycles, for done. Returns the result and the latency in cycles.
  task automatic run_op(input logic [2:0] opc, input logic [31:0] a, input logic [31:0] b,
                        input bit abuse, input string tag,
                        output logic [31:0] rhi, output logic [31:0] rlo,
                        output logic rdbz, output int lat);
    bit ok;
    drive(1'b1, opc, a, b);
    @(posedge clk); #1;
    drive(1'b0, OP_NOP, $urandom, $urandom);
    ok = (m_busy === 1'b1);
    lat = 0;
    do begin
      if (abuse && lat == 3) drive(1'b1, OP_DIVU, $urandom, 32'd5);
      if (abuse && lat == 5) drive(1'b0, OP_NOP, 32'd0, 32'd0);
      @(posedge clk); #1;
      lat++;
      if (m_done !== 1'b1) ok &= (m_busy === 1'b1) && (m_dbz === 1'b0);
      else                 ok &= (m_busy === 1'b0);
    end while (m_done !== 1'b1 && lat < 100);
    rhi  = m_hi;
    rlo  = m_lo;
    rdbz = m_dbz;
    check({tag, " busy profile"}, 64'(ok), 64'd1);
    @(posedge clk); #1;
    check({tag, " done pulse width"}, {62'd0, m_done, m_dbz}, 64'd0);
  endtask

  logic [31:0] r_hi, r_lo, e_hi, e_lo;
  logic        r_dbz, e_dbz;
  int          r_lat;
  logic [2:0]  ropc;
  logic [31:0] ra, rb;
  bit          seen_done;

  initial begin
    sel8 = 1'b0;
    rst = 1'b1;
    start = 1'b0; op = OP_NOP; src_a = 32'd0; src_b = 32'd0; flush = 1'b0;
    start8 = 1'b0; op8 = OP_NOP; a8 = 8'd0; b8 = 8'd0; flush8 = 1'b0;

    vecs[0] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33};
    vecs[1] = '{OP_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 33};
    vecs[2] = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33};
    vecs[3] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33};
    vecs[4] = '{OP_DIVU,  32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF, 1'b1, 1};
    vecs[5] = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 33};
    vecs[6] = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, 33};
    vecs[7] = '{OP_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, 1};
    vecs[8] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 33};
    vecs[9] = '{OP_MULT,  32'h80000000, 32'd1,        32'hFFFFFFFF, 32'h80000000, 1'b0, 33};

    // Reset state
    #12;
    check("reset hi", {32'd0, hi}, 64'd0);
    check("reset lo", {32'd0, lo}, 64'd0);
    check("reset busy/done/dbz", {61'd0, busy, done, dbz}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // MTHI then MTLO on consecutive cycles
    drive(1'b1, OP_MTHI, 32'h12345678, 32'd0);
    @(posedge clk); #1;
    check("mthi hi", {32'd0, hi}, 64'h12345678);
    check("mthi busy/done", {62'd0, busy, done}, 64'd0);
    drive(1'b1, OP_MTLO, 32'h9ABCDEF0, 32'd0);
    @(posedge clk); #1;
    drive(1'b0, OP_NOP, 32'd0, 32'd0);
    check("mtlo lo", {32'd0, lo}, 64'h9ABCDEF0);
    check("mtlo hi kept", {32'd0, hi}, 64'h12345678);
    check("mtlo busy/done", {62'd0, busy, done}, 64'd0);

    // Directed vector table
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, $sformatf("vec%0d", i), r_hi, r_lo, r_dbz, r_lat);
      check($sformatf("vec%0d hi", i), {32'd0, r_hi}, {32'd0, vecs[i].hi});
      check($sformatf("vec%0d lo", i), {32'd0, r_lo}, {32'd0, vecs[i].lo});
      check($sformatf("vec%0d dbz", i), 64'(r_dbz), 64'(vecs[i].dbz));
      check($sformatf("vec%0d latency", i), 64'(r_lat), 64'(vecs[i].lat));
    end

    // start with a different op while busy must be ignored
    run_op(OP_MULTU, 32'd6, 32'd7, 1'b1, "abuse", r_hi, r_lo, r_dbz, r_lat);
    check("abuse hi", {32'd0, r_hi}, 64'd0);
    check("abuse lo", {32'd0, r_lo}, 64'd42);
    check("abuse latency", 64'(r_lat), 64'd33);

    // flush at E10: busy drops at E11, hi/lo unchanged, no done
    drive(1'b1, OP_DIVU, 32'd1000, 32'd3);
    @(posedge clk); #1;
    drive(1'b0, OP_NOP, 32'd0, 32'd0);
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush busy", 64'(busy), 64'd0);
    seen_done = (done === 1'b1);
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen_done = 1'b1;
    end
    check("flush no done", 64'(seen_done), 64'd0);
    check("flush hi kept", {32'd0, hi}, 64'd0);
    check("flush lo kept", {32'd0, lo}, 64'd42);

    // flush together with start in IDLE: flush wins
    flush = 1'b1;
    drive(1'b1, OP_MTHI, 32'hDEADBEEF, 32'd0);
    @(posedge clk); #1;
    check("idle flush mthi", {32'd0, hi}, 64'd0);
    drive(1'b1, OP_MULTU, 32'd3, 32'd3);
    @(posedge clk); #1;
    check("idle flush start busy", 64'(busy), 64'd0);
    flush = 1'b0;
    drive(1'b0, OP_NOP, 32'd0, 32'd0);
    @(posedge clk); #1;

    // Random operations on the 32-bit instance
    for (int i = 0; i < 150; i++) begin
      ropc = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 15) == 0) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
      ref_model(32, ropc, ra, rb, e_hi, e_lo, e_dbz);
      run_op(ropc, ra, rb, 1'b0, $sformatf("r32_%0d", i), r_hi, r_lo, r_dbz, r_lat);
      check($sformatf("r32_%0d op%0d %h,%h hi", i, ropc, ra, rb), {32'd0, r_hi}, {32'd0, e_hi});
      check($sformatf("r32_%0d op%0d %h,%h lo", i, ropc, ra, rb), {32'd0, r_lo}, {32'd0, e_lo});
      check($sformatf("r32_%0d dbz", i), 64'(r_dbz), 64'(e_dbz));
      check($sformatf("r32_%0d latency", i), 64'(r_lat), e_dbz ? 64'd1 : 64'd33);
    end

    // WIDTH=8 instance
    sel8 = 1'b1;
    run_op(OP_MULTU, 32'hFF, 32'h02, 1'b0, "w8 multu", r_hi, r_lo, r_dbz, r_lat);
    check("w8 multu hi", {32'd0, r_hi}, 64'h01);
    check("w8 multu lo", {32'd0, r_lo}, 64'hFE);
    check("w8 multu latency", 64'(r_lat), 64'd9);
    for (int i = 0; i < 80; i++) begin
      ropc = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      ref_model(8, ropc, ra, rb, e_hi, e_lo, e_dbz);
      run_op(ropc, ra, rb, 1'b0, $sformatf("r8_%0d", i), r_hi, r_lo, r_dbz, r_lat);
      check($sformatf("r8_%0d op%0d %h,%h hi", i, ropc, ra[7:0], rb[7:0]), {32'd0, r_hi}, {32'd0, e_hi});
      check($sformatf("r8_%0d op%0d %h,%h lo", i, ropc, ra[7:0], rb[7:0]), {32'd0, r_lo}, {32'd0, e_lo});
      check($sformatf("r8_%0d dbz", i), 64'(r_dbz), 64'(e_dbz));
      check($sformatf("r8_%0d latency", i), 64'(r_lat), e_dbz ? 64'd1 : 64'd9);
    end
    sel8 = 1'b0;

    // Asynchronous reset mid-RUN, checked before the next clock edge
    drive(1'b1, OP_MTHI, 32'hA5A5A5A5, 32'd0);
    @(posedge clk); #1;
    drive(1'b1, OP_MTLO, 32'h5A5A5A5A, 32'd0);
    @(posedge clk); #1;
    drive(1'b1, OP_MULT, 32'd3, 32'd5);
    @(posedge clk); #1;
    drive(1'b0, OP_NOP, 32'd0, 32'd0);
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("async rst hi", {32'd0, hi}, 64'd0);
    check("async rst lo", {32'd0, lo}, 64'd0);
    check("async rst busy/done", {62'd0, busy, done}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    run_op(OP_MULT, 32'hFFFFFFFD, 32'd5, 1'b0, "post-reset", r_hi, r_lo, r_dbz, r_lat);
    check("post-reset hi", {32'd0, r_hi}, 64'hFFFFFFFF);
    check("post-reset lo", {32'd0, r_lo}, 64'hFFFFFFF1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
